// File: rtl/display_pkg.sv
// Shared display constants: ASCII codes, active-low 7-segment glyphs (bit 6 = g ... bit 0 = a)
// and the scroll controller state encoding.
package display_pkg;

  localparam int unsigned CHAR_W = 8;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned NUM_HEX = 6;

  localparam logic [CHAR_W-1:0] CH_A = 8'd65;
  localparam logic [CHAR_W-1:0] CH_b = 8'd98;
  localparam logic [CHAR_W-1:0] CH_C = 8'd67;
  localparam logic [CHAR_W-1:0] CH_d = 8'd100;
  localparam logic [CHAR_W-1:0] CH_E = 8'd69;
  localparam logic [CHAR_W-1:0] CH_F = 8'd70;
  localparam logic [CHAR_W-1:0] CH_g = 8'd103;
  localparam logic [CHAR_W-1:0] CH_h = 8'd104;

  localparam logic [SEG_W-1:0] SEG_A     = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h0E;
  localparam logic [SEG_W-1:0] SEG_G     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_H     = 7'h0B;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    SHIFT   = 2'd3
  } scroll_state_t;

endpackage

// File: rtl/hex_scroll_ctrl_if.sv
// Message-memory read port: controller drives the address, memory returns the
// character one cycle later.
interface hex_scroll_ctrl_if #(
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;

  modport master (output mem_addr, input mem_data);
  modport slave  (input mem_addr, output mem_data);
endinterface

// File: rtl/char_to_seg.sv
// Combinational ASCII to active-low 7-segment decoder; unknown codes blank.
module char_to_seg
  import display_pkg::*;
(
  input  logic [CHAR_W-1:0] char_code,
  output logic [SEG_W-1:0]  seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (char_code)
      CH_A:    seg_c = SEG_A;
      CH_b:    seg_c = SEG_B;
      CH_C:    seg_c = SEG_C;
      CH_d:    seg_c = SEG_D;
      CH_E:    seg_c = SEG_E;
      CH_F:    seg_c = SEG_F;
      CH_g:    seg_c = SEG_G;
      CH_h:    seg_c = SEG_H;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Scroll controller: walks the message memory and shifts decoded characters
// right-to-left across six displays, on a periodic tick (run) or single step.
module hex_scroll_ctrl
  import display_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned MSG_LEN  = 8,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              run,
  input  logic              step,
  hex_scroll_ctrl_if.master mem,
  output logic [SEG_W-1:0]  HEX0,
  output logic [SEG_W-1:0]  HEX1,
  output logic [SEG_W-1:0]  HEX2,
  output logic [SEG_W-1:0]  HEX3,
  output logic [SEG_W-1:0]  HEX4,
  output logic [SEG_W-1:0]  HEX5,
  output logic              busy,
  output logic              wrap
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MSG_LEN - 1);

  scroll_state_t                  state;
  logic [CNT_W-1:0]               tick_cnt;
  logic                           tick_c;
  logic [ADDR_W-1:0]              addr_q;
  logic [CHAR_W-1:0]              char_q;
  logic [SEG_W-1:0]               seg_c;
  logic [NUM_HEX-1:0][SEG_W-1:0]  hex_q;

  // Free-running scroll timer, held at zero while stopped
  assign tick_c = run && (tick_cnt == CNT_LAST);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      tick_cnt <= '0;
    end else if (!run) begin
      tick_cnt <= '0;
    end else if (tick_cnt == CNT_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  char_to_seg u_char_to_seg (
    .char_code (char_q),
    .seg_c     (seg_c)
  );

  // Fetch/capture/shift sequencer with address counter and display shift register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state  <= IDLE;
      addr_q <= '0;
      char_q <= '0;
      hex_q  <= {NUM_HEX{SEG_BLANK}};
      busy   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (state)
        IDLE: begin
          // step only counts while stopped; with run high the tick owns the sequencer
          if (tick_c || (step && !run)) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          char_q <= mem.mem_data;
          state  <= SHIFT;
        end
        SHIFT: begin
          hex_q  <= {hex_q[NUM_HEX-2:0], seg_c};
          addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
          wrap   <= (addr_q == ADDR_LAST);
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_addr = addr_q;
  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Directed bench for hex_scroll_ctrl with a 1-cycle-latency message memory holding "AbC".
module tb_hex_scroll_ctrl;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned MSG_LEN  = 3;
  localparam int unsigned ADDR_W   = 5;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       run   = 1'b0;
  logic       step  = 1'b0;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic       busy, wrap;
  logic [7:0] mem [32];

  int total = 0;
  int bad   = 0;

  hex_scroll_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  always #5 clk = ~clk;

  always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];

  hex_scroll_ctrl #(
    .TICK_DIV (TICK_DIV),
    .MSG_LEN  (MSG_LEN),
    .ADDR_W   (ADDR_W)
  ) dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .run    (run),
    .step   (step),
    .mem    (bus),
    .HEX0   (hex0),
    .HEX1   (hex1),
    .HEX2   (hex2),
    .HEX3   (hex3),
    .HEX4   (hex4),
    .HEX5   (hex5),
    .busy   (busy),
    .wrap   (wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One step pulse from a negedge; checks busy, 3-cycle latency, glyph and wrap; 5 cycles total
  task automatic step_pulse(input string tag, input logic [6:0] prev,
                            input logic [6:0] exp, input logic exp_wrap);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_early"}, 32'(hex0), 32'(prev));
    @(negedge clk);
    chk({tag, "_hex0"}, 32'(hex0), 32'(exp));
    chk({tag, "_wrap"}, 32'(wrap), 32'(exp_wrap));
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  function automatic logic [6:0] run_hex0(input int k);
    if (k < 7)  return 7'h46;
    if (k < 11) return 7'h08;
    if (k < 15) return 7'h03;
    if (k < 19) return 7'h46;
    return 7'h08;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h20;
    mem[0] = 8'd65;
    mem[1] = 8'd98;
    mem[2] = 8'd67;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_hex0", 32'(hex0), 32'h7F);
    chk("rst_hex5", 32'(hex5), 32'h7F);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single steps through "AbC"
    step_pulse("s1", 7'h7F, 7'h08, 1'b0);
    chk("s1_addr", 32'(bus.mem_addr), 32'd1);
    step_pulse("s2", 7'h08, 7'h03, 1'b0);
    step_pulse("s3", 7'h03, 7'h46, 1'b1);
    chk("s3_hex1", 32'(hex1), 32'h03);
    chk("s3_hex2", 32'(hex2), 32'h08);
    chk("s3_hex3", 32'(hex3), 32'h7F);
    chk("s3_hex4", 32'(hex4), 32'h7F);
    chk("s3_hex5", 32'(hex5), 32'h7F);
    chk("s3_addr", 32'(bus.mem_addr), 32'd0);
    chk("s3_wrap_done", 32'(wrap), 32'd0);

    // Continuous run with colliding steps; run dropped while in CAPTURE of the 4th sequence
    run = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      chk($sformatf("run_hex0_%0d", k), 32'(hex0), 32'(run_hex0(k)));
      chk($sformatf("run_busy_%0d", k), 32'(busy),
          32'((k >= 4 && k <= 18 && (k % 4) != 3) ? 1 : 0));
      chk($sformatf("run_wrap_%0d", k), 32'(wrap), 32'((k == 15) ? 1 : 0));
      if (k == 1)  step = 1'b1;
      if (k == 2)  step = 1'b0;
      if (k == 5)  step = 1'b1;
      if (k == 6)  step = 1'b0;
      if (k == 17) run  = 1'b0;
    end
    chk("run_hex1", 32'(hex1), 32'h46);
    chk("run_hex2", 32'(hex2), 32'h03);
    chk("run_hex3", 32'(hex3), 32'h08);
    chk("run_hex4", 32'(hex4), 32'h46);
    chk("run_hex5", 32'(hex5), 32'h03);
    chk("run_addr", 32'(bus.mem_addr), 32'd1);

    // Second step while busy is dropped
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (8) @(negedge clk);
    chk("coll_hex0", 32'(hex0), 32'h03);
    chk("coll_hex1", 32'(hex1), 32'h08);
    chk("coll_addr", 32'(bus.mem_addr), 32'd2);
    chk("coll_busy", 32'(busy), 32'd0);

    // Unknown and blank codes, plus further glyphs
    mem[2] = 8'h5A;
    step_pulse("unk5a", 7'h03, 7'h7F, 1'b1);
    mem[0] = 8'h20;
    step_pulse("space", 7'h7F, 7'h7F, 1'b0);
    chk("space_hex2", 32'(hex2), 32'h03);
    mem[1] = 8'd100;
    step_pulse("d", 7'h7F, 7'h21, 1'b0);
    mem[2] = 8'd69;
    step_pulse("E", 7'h21, 7'h06, 1'b1);
    chk("E_hex4", 32'(hex4), 32'h03);

    // Asynchronous reset in the middle of a running sequence
    run = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_hex0", 32'(hex0), 32'h7F);
    chk("arst_hex1", 32'(hex1), 32'h7F);
    chk("arst_hex4", 32'(hex4), 32'h7F);
    chk("arst_addr", 32'(bus.mem_addr), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    run   = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_hex0", 32'(hex0), 32'h7F);
    chk("post_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
